// File: rtl/we_reg_arbiter_pkg.sv
// we_arb_pkg: shared types and helpers for the write-enabled register arbiter
package we_arb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, ACK} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/we_reg_arbiter_rr_pick.sv
// rr_pick: first set request bit searching upward from ptr, wrapping modulo NREQ
module rr_pick
  import we_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  output logic [idx_w(NREQ)-1:0]  grant,
  output logic                    valid
);
  localparam int IW = idx_w(NREQ);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |req;
    // Walk offsets high to low so the smallest offset from ptr is the last to win
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/we_reg_arbiter.sv
// we_reg_arbiter: round-robin sequencer sharing one write-enabled register between NREQ requesters
module we_reg_arbiter
  import we_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DW-1:0]          q,
  output logic [idx_w(NREQ)-1:0] owner,
  output logic                   busy,
  output logic [7:0]             wr_cnt
);
  localparam int IW = idx_w(NREQ);
  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, owner_q, owner_d, pick_g;
  logic [DW-1:0] dat_q, dat_d, q_q, q_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pick_v, we;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_g),
    .valid (pick_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      dat_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      dat_q   <= dat_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    dat_d   = dat_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (pick_v) begin
        g_d     = pick_g;
        dat_d   = wdata[pick_g*DW +: DW];
        state_d = WRITE;
      end
      WRITE: begin
        we      = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        owner_d = g_q;
        cnt_d   = cnt_q + 8'd1;
        ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    q_d = we ? dat_q : q_q;
  end

  assign ack    = (state_q == ACK) ? NREQ'(1) << g_q : '0;
  assign busy   = state_q != IDLE;
  assign q      = q_q;
  assign owner  = owner_q;
  assign wr_cnt = cnt_q;
endmodule

// File: tb/tb_we_reg_arbiter.sv
// tb_we_reg_arbiter: directed and randomized checks of we_reg_arbiter against a behavioural model
module tb_we_reg_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  wr_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr, m_owner, m_cnt, m_q;

  we_reg_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .ack    (ack),
    .q      (q),
    .owner  (owner),
    .busy   (busy),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    check("rst_q", q, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", wr_cnt, 0);
    check("rst_owner", owner, 0);
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_q = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic serve(input bit drop, input int exp_g);
    int g;
    logic [7:0] d;
    g = pick(req, m_ptr);
    if (exp_g >= 0) check("grant_order", g, exp_g);
    d = wdata[g*8 +: 8];
    @(negedge clk);
    check("busy_write", busy, 1);
    check("ack_write", ack, 0);
    if (drop) req[g] = 1'b0;
    @(negedge clk);
    check("q_ack", q, d);
    check("ack_pulse", ack, 32'd1 << g);
    req[g] = 1'b0;
    m_q = d; m_owner = g; m_cnt = (m_cnt + 1) % 256; m_ptr = (g + 1) % 4;
    @(negedge clk);
    check("ack_idle", ack, 0);
    check("busy_idle", busy, 0);
    check("owner", owner, m_owner);
    check("wr_cnt", wr_cnt, m_cnt);
    check("q_hold", q, m_q);
  endtask

  initial begin
    do_reset();
    // idle with no request stays idle
    @(negedge clk);
    check("idle_busy", busy, 0);
    // single request
    req = 4'b0100; wdata = 32'h00A5_0000;
    serve(1'b0, 2);
    check("single_q", q, 8'hA5);
    check("single_owner", owner, 2);
    check("single_cnt", wr_cnt, 1);
    // round-robin with all four requesting
    do_reset();
    req = 4'b1111; wdata = 32'h1312_1110;
    for (int i = 0; i < 4; i++) serve(1'b0, i);
    check("rr_q", q, 8'h13);
    check("rr_cnt", wr_cnt, 4);
    // rotation after wrap
    do_reset();
    req = 4'b1000; wdata = 32'h4400_0033;
    serve(1'b0, 3);
    req = 4'b1001;
    serve(1'b0, 0);
    serve(1'b0, 3);
    // reset during WRITE aborts the write
    do_reset();
    req = 4'b0010; wdata = 32'h0000_7700;
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("mid_q", q, 0);
    check("mid_ack", ack, 0);
    check("mid_busy_rst", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_idle_ack", ack, 0);
    check("mid_idle_busy", busy, 0);
    check("mid_cnt", wr_cnt, 0);
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_q = 0;
    req = 4'b1111; wdata = 32'h0403_0201;
    serve(1'b0, 0);
    // 256 random single-requester writes wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      req = 4'b0001 << $urandom_range(0, 3);
      wdata = $urandom;
      serve(1'b0, -1);
    end
    check("cnt_wrap", wr_cnt, 0);
    // request withdrawn during WRITE still completes
    req = 4'b0100; wdata = 32'h005A_0000;
    serve(1'b1, pick(4'b0100, m_ptr));
    check("drop_q", q, 8'h5A);
    // random multi-request traffic
    for (int i = 0; i < 40; i++) begin
      req = 4'($urandom_range(1, 15));
      wdata = $urandom;
      serve(1'($urandom_range(0, 1)), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/we_reg_arbiter.md
# we_reg_arbiter

Round-robin arbiter and sequencer that shares a single write-enabled storage register between NREQ requesters. Each requester presents a request and a data word. The block selects one winner, drives a one-cycle write enable into the storage register, and returns a one-cycle acknowledge to the winner. It sits between the SNN control units and the shared configuration/state register they all update.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- DW, 8: data and storage width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester write request, level; held until ack.
- wdata  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- ack  output  NREQ  one-hot, one-cycle pulse marking a completed write.
- q  output  DW  current contents of the shared register.
- owner  output  $clog2(NREQ)  index of the requester that made the most recent write.
- busy  output  1  high when the FSM is in any state other than IDLE.
- wr_cnt  output  8  count of completed writes; wraps from 255 to 0.

## Operation
- FSM has three states: IDLE, WRITE, ACK.
- **IDLE**
  - If any req bit is high, select winner g as the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Latch g and wdata[g*DW +: DW] into internal registers, then go to WRITE.
  - If no req bit is high, stay in IDLE.
- **WRITE**
  - Register write enable we is high for exactly this cycle.
  - The storage register captures the latched data at the edge that ends WRITE.
  - Next state is ACK.
- **ACK**
  - ack[g] = 1; all other ack bits are 0.
  - owner <= g and wr_cnt <= wr_cnt + 1, mod 256.
  - ptr <= (g + 1) mod NREQ.
  - Next state is IDLE.
- req is ignored in WRITE and ACK.
- A request that drops after being latched still completes its write and ack.
- Requester contract: deassert req at the clock edge that ends the ack cycle. A req still high in the following IDLE cycle counts as a new request.
- ack, we and busy come directly from state decode or registers. There is no combinational path from req to any output.
- Reset values:
  - state = IDLE, ptr = 0.
  - q = 0, owner = 0, wr_cnt = 0.
  - ack = 0, busy = 0, we = 0.
- Reset asserted mid-operation:
  - The FSM aborts immediately and no write completes.
  - q returns to 0.
  - A pending requester must re-request after reset.

## Timing
- Cycle T: IDLE samples req.
- Cycle T+1: WRITE; busy = 1.
- Cycle T+2: ACK; q already holds the new value and ack[g] = 1.
- Cycle T+3: IDLE; the earliest next grant is sampled here.
- Latency from req sampled to q updated is 2 clocks. Maximum throughput is one write per 3 clocks.
- Simultaneous requests are served strictly round-robin. With all NREQ bits held, the grant order from reset is 0,1,2,…,NREQ-1,0,…
- Starvation bound: a held req is granted within NREQ grants.
- A single requester holding req continuously is granted every 3 cycles, because ptr wraps past it back to itself.
- ptr wraps from NREQ-1 to 0.

## Structure
- Package `we_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, WRITE, ACK};
  - the localparam width function for the owner index.
- Natural sub-module: `rr_pick`.
  - Purely combinational.
  - Inputs: req, ptr. Outputs: grant index and a valid flag.
  - Keeps the priority-rotation logic separately testable.
- The shared register is a plain DW-bit flop with write enable, inside this block, reset to 0.

## Test plan
- **Reset:** hold rst_n = 0 for 2 cycles → q = 0, ack = 0, busy = 0, wr_cnt = 0, owner = 0.
- **Single request:** req = 4'b0100, wdata[2] = 8'hA5 → busy = 1 in the next cycle. Two cycles after sampling, q = 8'hA5, ack = 4'b0100 for one cycle, owner = 2, wr_cnt = 1.
- **Round-robin:** req = 4'b1111 with wdata i = 8'h10+i, each requester dropping req after its ack → acks in order 0,1,2,3 at 3-cycle spacing. Final q = 8'h13, wr_cnt = 4.
- **Rotation after wrap:** grant requester 3, then req = 4'b1001 → requester 0 wins (ptr wrapped to 0). Next grant is requester 3.
- **Reset mid-write:** assert rst_n low during WRITE for requester 1 with data 8'h77 → q = 0, no ack pulse, FSM in IDLE, ptr = 0 after release.
- **Counter wrap and withdrawn request:**
  - 256 back-to-back single-requester writes → wr_cnt returns to 0.
  - A req dropped in the WRITE cycle still produces its ack and q update.
